// File: rtl/sdram_bus_pkg.sv
// Shared types and constants for the SDRAM port arbiter.
//   state_t        : arbiter FSM states (IDLE, ARM, WAIT, GAP)
//   RD_STRB        : strobe pattern that marks a read
//   TIMEOUT_RDATA  : read data returned to a requester whose transaction was aborted
//   req_t          : one requester's payload {addr, wdata, wstrb}
package sdram_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    WAIT,
    GAP
  } state_t;

  localparam logic [3:0]  RD_STRB       = 4'h0;
  localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

  // Address field width of req_t; the arbiter's ADDR_W must not exceed it.
  localparam int REQ_ADDR_W = 32;

  typedef struct packed {
    logic [REQ_ADDR_W-1:0] addr;
    logic [31:0]           wdata;
    logic [3:0]            wstrb;
  } req_t;

endpackage

// File: rtl/sdram_rr_arb2.sv
// Two-way grant selection with optional fixed priority for port 0.
//   clk, rst   : clock, asynchronous active-high reset
//   req[1:0]   : per-port request levels
//   done       : pulse when the granted transaction finishes
//   done_port  : index of the port that just finished
//   any        : at least one port is requesting
//   gnt        : winning port index (valid when any=1)
// rr_last remembers the last port served; on a tie the other port wins.
// It resets to 1 so port 0 wins the very first tie.
module sdram_rr_arb2 #(
  parameter int P0_PRIORITY = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       done,
  input  logic       done_port,
  output logic       any,
  output logic       gnt
);

  logic rr_last_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_last_reg <= 1'b1;
    end else if (done) begin
      rr_last_reg <= done_port;
    end
  end

  always_comb begin
    any = |req;
    gnt = 1'b0;
    if (req == 2'b11) begin
      gnt = (P0_PRIORITY != 0) ? 1'b0 : ~rr_last_reg;
    end else begin
      gnt = req[1] & ~req[0];
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Two-requester arbiter/bridge in front of the SDRAM controller port.
//   clk, rst                     : clock, asynchronous active-high reset
//   p0_* (packet-buffer DMA)     : valid/addr/wdata/wstrb in, ready/rdata out
//   p1_* (CPU)                   : same as port 0
//   m_valid/m_addr/m_wdata/m_wstrb : registered request to the controller
//   m_ready/m_rdata              : controller completion and read data
//   timeout                      : sticky flag, set when a transaction is aborted
// ADDR_W must be <= sdram_bus_pkg::REQ_ADDR_W.
// One transaction is in flight at a time. The request is copied into m_*
// at grant, so requester payload changes while granted have no effect.
module sdram_port_arbiter
  import sdram_bus_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 1024,
  parameter int P0_PRIORITY = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_valid,
  output logic              p0_ready,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [31:0]       p0_wdata,
  input  logic [3:0]        p0_wstrb,
  output logic [31:0]       p0_rdata,
  input  logic              p1_valid,
  output logic              p1_ready,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [31:0]       p1_wdata,
  input  logic [3:0]        p1_wstrb,
  output logic [31:0]       p1_rdata,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [ADDR_W-1:0] m_addr,
  output logic [31:0]       m_wdata,
  output logic [3:0]        m_wstrb,
  input  logic [31:0]       m_rdata,
  output logic              timeout
);

  localparam int                CNT_W    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0]  CNT_SAT  = '1;

  state_t            state_reg, state_next;
  logic              gnt_reg, gnt_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  req_t              m_req_reg, m_req_next;
  logic              m_valid_reg, m_valid_next;
  logic              timeout_reg, timeout_next;
  logic              ready_reg  [2];
  logic              ready_next [2];
  logic [31:0]       rdata_reg  [2];
  logic [31:0]       rdata_next [2];

  req_t              p_req [2];
  logic              arb_any;
  logic              arb_gnt;
  logic              arb_done;

  always_comb begin
    p_req[0].addr  = REQ_ADDR_W'(p0_addr);
    p_req[0].wdata = p0_wdata;
    p_req[0].wstrb = p0_wstrb;
    p_req[1].addr  = REQ_ADDR_W'(p1_addr);
    p_req[1].wdata = p1_wdata;
    p_req[1].wstrb = p1_wstrb;
  end

  sdram_rr_arb2 #(
    .P0_PRIORITY (P0_PRIORITY)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       ({p1_valid, p0_valid}),
    .done      (arb_done),
    .done_port (gnt_reg),
    .any       (arb_any),
    .gnt       (arb_gnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      gnt_reg      <= 1'b0;
      cnt_reg      <= '0;
      m_req_reg    <= '0;
      m_valid_reg  <= 1'b0;
      timeout_reg  <= 1'b0;
      ready_reg[0] <= 1'b0;
      ready_reg[1] <= 1'b0;
      rdata_reg[0] <= '0;
      rdata_reg[1] <= '0;
    end else begin
      state_reg    <= state_next;
      gnt_reg      <= gnt_next;
      cnt_reg      <= cnt_next;
      m_req_reg    <= m_req_next;
      m_valid_reg  <= m_valid_next;
      timeout_reg  <= timeout_next;
      ready_reg[0] <= ready_next[0];
      ready_reg[1] <= ready_next[1];
      rdata_reg[0] <= rdata_next[0];
      rdata_reg[1] <= rdata_next[1];
    end
  end

  always_comb begin
    state_next    = state_reg;
    gnt_next      = gnt_reg;
    cnt_next      = cnt_reg;
    m_req_next    = m_req_reg;
    m_valid_next  = m_valid_reg;
    timeout_next  = timeout_reg;
    ready_next[0] = 1'b0;
    ready_next[1] = 1'b0;
    rdata_next    = rdata_reg;
    arb_done      = 1'b0;

    case (state_reg)
      IDLE: begin
        if (arb_any) begin
          m_req_next   = p_req[arb_gnt];
          m_valid_next = 1'b1;
          gnt_next     = arb_gnt;
          cnt_next     = '0;
          state_next   = ARM;
        end
      end

      ARM, WAIT: begin
        if (cnt_reg != CNT_SAT) begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
        // ARM exists only to see m_ready low once, so a ready level left
        // high from controller init is never mistaken for completion.
        if ((state_reg == WAIT) && m_ready) begin
          if (m_req_reg.wstrb == RD_STRB) begin
            rdata_next[gnt_reg] = m_rdata;
          end
          ready_next[gnt_reg] = 1'b1;
          m_valid_next        = 1'b0;
          arb_done            = 1'b1;
          state_next          = GAP;
        end else if (cnt_reg == CNT_LAST) begin
          rdata_next[gnt_reg] = TIMEOUT_RDATA;
          ready_next[gnt_reg] = 1'b1;
          m_valid_next        = 1'b0;
          timeout_next        = 1'b1;
          arb_done            = 1'b1;
          state_next          = GAP;
        end else if ((state_reg == ARM) && !m_ready) begin
          state_next = WAIT;
        end
      end

      // One dead cycle with m_valid low so the controller never re-samples
      // the finished request as a new one.
      GAP: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign m_valid  = m_valid_reg;
  assign m_addr   = ADDR_W'(m_req_reg.addr);
  assign m_wdata  = m_req_reg.wdata;
  assign m_wstrb  = m_req_reg.wstrb;
  assign p0_ready = ready_reg[0];
  assign p1_ready = ready_reg[1];
  assign p0_rdata = rdata_reg[0];
  assign p1_rdata = rdata_reg[1];
  assign timeout  = timeout_reg;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Scoreboard bench for sdram_port_arbiter. Two instances: index 0 runs
// round-robin, index 1 gives port 0 fixed priority; both use TIMEOUT_CYC=16.
// Expected completions are queued by the stimulus; a monitor per instance
// pops and compares on every port ready pulse.
module tb_sdram_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        p0_valid [2];
  logic        p0_ready [2];
  logic [31:0] p0_addr  [2];
  logic [31:0] p0_wdata [2];
  logic [3:0]  p0_wstrb [2];
  logic [31:0] p0_rdata [2];
  logic        p1_valid [2];
  logic        p1_ready [2];
  logic [31:0] p1_addr  [2];
  logic [31:0] p1_wdata [2];
  logic [3:0]  p1_wstrb [2];
  logic [31:0] p1_rdata [2];
  logic        m_valid  [2];
  logic [31:0] m_addr   [2];
  logic [31:0] m_wdata  [2];
  logic [3:0]  m_wstrb  [2];
  logic        timeout  [2];

  bit          auto_en   [2];
  logic        man_ready [2];
  logic [31:0] man_rdata [2];

  typedef struct {
    int          dut;
    int          port;
    logic [31:0] rdata;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        tmo;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push(input int d, input int port, input logic [31:0] rdata,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] wstrb, input logic tmo);
    exp_t e;
    e.dut = d; e.port = port; e.rdata = rdata; e.addr = addr;
    e.wdata = wdata; e.wstrb = wstrb; e.tmo = tmo;
    exp_q.push_back(e);
  endtask

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      logic        auto_ready = 1'b0;
      logic [31:0] auto_rdata = '0;
      logic        m_ready_s;
      logic [31:0] m_rdata_s;
      assign m_ready_s = auto_en[gi] ? auto_ready : man_ready[gi];
      assign m_rdata_s = auto_en[gi] ? auto_rdata : man_rdata[gi];

      sdram_port_arbiter #(
        .ADDR_W      (32),
        .TIMEOUT_CYC (16),
        .P0_PRIORITY (gi)
      ) dut (
        .clk      (clk),
        .rst      (rst),
        .p0_valid (p0_valid[gi]),
        .p0_ready (p0_ready[gi]),
        .p0_addr  (p0_addr[gi]),
        .p0_wdata (p0_wdata[gi]),
        .p0_wstrb (p0_wstrb[gi]),
        .p0_rdata (p0_rdata[gi]),
        .p1_valid (p1_valid[gi]),
        .p1_ready (p1_ready[gi]),
        .p1_addr  (p1_addr[gi]),
        .p1_wdata (p1_wdata[gi]),
        .p1_wstrb (p1_wstrb[gi]),
        .p1_rdata (p1_rdata[gi]),
        .m_valid  (m_valid[gi]),
        .m_ready  (m_ready_s),
        .m_addr   (m_addr[gi]),
        .m_wdata  (m_wdata[gi]),
        .m_wstrb  (m_wstrb[gi]),
        .m_rdata  (m_rdata_s),
        .timeout  (timeout[gi])
      );

      // Controller model: completes two cycles after seeing a request,
      // returning addr + 0x5000_0000 as read data.
      initial begin
        int cnt = 0;
        forever begin
          @(posedge clk);
          #1;
          if (!auto_en[gi]) begin
            cnt = 0;
            auto_ready = 1'b0;
          end else if (auto_ready) begin
            auto_ready = 1'b0;
          end else if (m_valid[gi]) begin
            cnt++;
            if (cnt >= 2) begin
              auto_ready = 1'b1;
              auto_rdata = m_addr[gi] + 32'h5000_0000;
              cnt = 0;
            end
          end else begin
            cnt = 0;
          end
        end
      end

      // Monitor: one pop and compare per ready pulse.
      initial begin
        exp_t e;
        forever begin
          @(negedge clk);
          if (!rst && (p0_ready[gi] || p1_ready[gi])) begin
            if (exp_q.size() == 0) begin
              n_cmp++;
              n_bad++;
              $display("FAIL unexpected_ready: dut%0d got p0_ready=%0b p1_ready=%0b, expected none",
                       gi, p0_ready[gi], p1_ready[gi]);
            end else begin
              e = exp_q.pop_front();
              $display("txn dut%0d port%0d addr=%h wstrb=%h p0_rdata=%h p1_rdata=%h timeout=%0b",
                       gi, p1_ready[gi] ? 1 : 0, m_addr[gi], m_wstrb[gi],
                       p0_rdata[gi], p1_rdata[gi], timeout[gi]);
              chk("dut_index", gi, e.dut);
              chk("ready_port", p1_ready[gi] ? 1 : 0, e.port);
              chk("ready_onehot", {31'd0, p0_ready[gi] & p1_ready[gi]}, 32'd0);
              chk("port_rdata", (e.port == 1) ? p1_rdata[gi] : p0_rdata[gi], e.rdata);
              chk("m_addr", m_addr[gi], e.addr);
              chk("m_wdata", m_wdata[gi], e.wdata);
              chk("m_wstrb", {28'd0, m_wstrb[gi]}, {28'd0, e.wstrb});
              chk("m_valid_gap", {31'd0, m_valid[gi]}, 32'd0);
              chk("timeout_flag", {31'd0, timeout[gi]}, {31'd0, e.tmo});
            end
          end
        end
      end
    end
  endgenerate

  task automatic set_req(input int d, input int port, input logic v, input logic [31:0] a,
                         input logic [31:0] w, input logic [3:0] s);
    if (port == 0) begin
      p0_valid[d] = v; p0_addr[d] = a; p0_wdata[d] = w; p0_wstrb[d] = s;
    end else begin
      p1_valid[d] = v; p1_addr[d] = a; p1_wdata[d] = w; p1_wstrb[d] = s;
    end
  endtask

  task automatic wait_port_ready(input int d, input int port);
    bit seen = 1'b0;
    for (int k = 0; k < 300 && !seen; k++) begin
      @(posedge clk);
      #1;
      seen = (port == 0) ? p0_ready[d] : p1_ready[d];
    end
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_ready: dut%0d port%0d got no ready in 300 cycles, expected a pulse", d, port);
    end
  endtask

  // Present a request, hold it until ready, then drop valid if it is the last.
  task automatic req_item(input int d, input int port, input logic [31:0] a,
                          input logic [31:0] w, input logic [3:0] s, input bit last);
    set_req(d, port, 1'b1, a, w, s);
    wait_port_ready(d, port);
    if (last) set_req(d, port, 1'b0, '0, '0, '0);
  endtask

  task automatic wait_m_valid(input int d);
    bit seen = 1'b0;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(posedge clk);
      #1;
      seen = m_valid[d];
    end
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_m_valid: dut%0d got m_valid=0 for 50 cycles, expected 1", d);
    end
  endtask

  task automatic chk_reset(input int d);
    chk("rst_m_valid",  {31'd0, m_valid[d]}, 32'd0);
    chk("rst_m_addr",   m_addr[d], 32'd0);
    chk("rst_m_wdata",  m_wdata[d], 32'd0);
    chk("rst_m_wstrb",  {28'd0, m_wstrb[d]}, 32'd0);
    chk("rst_p0_ready", {31'd0, p0_ready[d]}, 32'd0);
    chk("rst_p1_ready", {31'd0, p1_ready[d]}, 32'd0);
    chk("rst_p0_rdata", p0_rdata[d], 32'd0);
    chk("rst_p1_rdata", p1_rdata[d], 32'd0);
    chk("rst_timeout",  {31'd0, timeout[d]}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    for (int d = 0; d < 2; d++) begin
      set_req(d, 0, 1'b0, '0, '0, '0);
      set_req(d, 1, 1'b0, '0, '0, '0);
      auto_en[d]   = 1'b0;
      man_ready[d] = 1'b0;
      man_rdata[d] = '0;
    end
    // Controller ready already high out of reset.
    man_ready[0] = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset(0);
    chk_reset(1);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // 1: stale high m_ready must not complete the read.
    push(0, 0, 32'h1234_5678, 32'h0000_0040, 32'h0, 4'h0, 1'b0);
    set_req(0, 0, 1'b1, 32'h0000_0040, 32'h0, 4'h0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      chk("t1_m_valid_held", {31'd0, m_valid[0]}, 32'd1);
      chk("t1_no_p0_ready", {31'd0, p0_ready[0]}, 32'd0);
    end
    man_ready[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    man_rdata[0] = 32'h1234_5678;
    man_ready[0] = 1'b1;
    wait_port_ready(0, 0);
    set_req(0, 0, 1'b0, '0, '0, '0);
    man_ready[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // 2: write; p1_rdata must stay at its reset value.
    auto_en[0] = 1'b1;
    push(0, 1, 32'h0, 32'h0000_0100, 32'hCAFE_F00D, 4'b0011, 1'b0);
    req_item(0, 1, 32'h0000_0100, 32'hCAFE_F00D, 4'b0011, 1'b1);
    repeat (3) @(posedge clk);
    #1;

    // 3: constant contention, round-robin -> 0,1,0,1.
    push(0, 0, 32'h5000_0200, 32'h200, 32'h0, 4'h0, 1'b0);
    push(0, 1, 32'h5000_0300, 32'h300, 32'h0, 4'h0, 1'b0);
    push(0, 0, 32'h5000_0204, 32'h204, 32'h0, 4'h0, 1'b0);
    push(0, 1, 32'h5000_0304, 32'h304, 32'h0, 4'h0, 1'b0);
    fork
      begin
        req_item(0, 0, 32'h200, 32'h0, 4'h0, 1'b0);
        req_item(0, 0, 32'h204, 32'h0, 4'h0, 1'b1);
      end
      begin
        req_item(0, 1, 32'h300, 32'h0, 4'h0, 1'b0);
        req_item(0, 1, 32'h304, 32'h0, 4'h0, 1'b1);
      end
    join
    repeat (3) @(posedge clk);
    #1;

    // 5: controller stuck; abort after 16 cycles, flag is sticky.
    auto_en[0]   = 1'b0;
    man_ready[0] = 1'b0;
    push(0, 0, 32'hDEAD_BEEF, 32'h80, 32'h0, 4'h0, 1'b1);
    set_req(0, 0, 1'b1, 32'h80, 32'h0, 4'h0);
    wait_m_valid(0);
    k = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      k++;
      if (p0_ready[0]) break;
    end
    chk("t5_timeout_latency", k, 16);
    set_req(0, 0, 1'b0, '0, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    auto_en[0] = 1'b1;
    push(0, 0, 32'h5000_0084, 32'h84, 32'h0, 4'h0, 1'b1);
    req_item(0, 0, 32'h84, 32'h0, 4'h0, 1'b1);
    repeat (3) @(posedge clk);
    #1;

    // 6: reset in WAIT clears outputs immediately; lost request not retried.
    auto_en[0]   = 1'b0;
    man_ready[0] = 1'b0;
    set_req(0, 1, 1'b1, 32'h400, 32'h0, 4'h0);
    wait_m_valid(0);
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk_reset(0);
    set_req(0, 1, 1'b0, '0, '0, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    auto_en[0] = 1'b1;
    push(0, 1, 32'h5000_0500, 32'h500, 32'h0, 4'h0, 1'b0);
    req_item(0, 1, 32'h500, 32'h0, 4'h0, 1'b1);
    repeat (3) @(posedge clk);
    #1;

    // 4: fixed priority instance; port 1 waits until port 0 lets go.
    auto_en[1] = 1'b1;
    push(1, 0, 32'h5000_0600, 32'h600, 32'h0, 4'h0, 1'b0);
    push(1, 0, 32'h5000_0604, 32'h604, 32'h0, 4'h0, 1'b0);
    push(1, 0, 32'h5000_0608, 32'h608, 32'h0, 4'h0, 1'b0);
    push(1, 0, 32'h5000_060C, 32'h60C, 32'h0, 4'h0, 1'b0);
    push(1, 1, 32'h5000_0700, 32'h700, 32'h0, 4'h0, 1'b0);
    fork
      begin
        req_item(1, 0, 32'h600, 32'h0, 4'h0, 1'b0);
        req_item(1, 0, 32'h604, 32'h0, 4'h0, 1'b0);
        req_item(1, 0, 32'h608, 32'h0, 4'h0, 1'b0);
        req_item(1, 0, 32'h60C, 32'h0, 4'h0, 1'b1);
      end
      begin
        req_item(1, 1, 32'h700, 32'h0, 4'h0, 1'b1);
      end
    join
    repeat (5) @(posedge clk);
    #1;

    chk("queue_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
